// File: rtl/master_bus_arbiter_pkg.sv
// master_bus_arbiter_pkg: shared state and owner types for the two-master bus arbiter
package master_bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} arb_state_t;
    typedef enum logic {OWNER_A, OWNER_B} owner_t;
endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: counts unacknowledged ownership cycles and flags expiry (TIMEOUT_CYCLES=0 disables)
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d   = clear ? '0 : enable ? cnt_q + CNT_W'(1) : cnt_q;
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/master_bus_arbiter.sv
// master_bus_arbiter: grants the shared bus to master A or B, with ack tracking and hung-transfer timeout.
// Define ARB_ROUND_ROBIN_EN to alternate on contention instead of fixed priority to A.
module master_bus_arbiter
    import master_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reqA,
    input  logic reqB,
    input  logic busAck,
    output logic useA,
    output logic grantA,
    output logic grantB,
    output logic busValid,
    output logic timeoutErr
);
    arb_state_t state_q, state_d;
    logic       useA_q, useA_d;
    logic       err_q, err_d;
    logic       own, own_req, cnt_en, expired, prefer_b;

    function automatic arb_state_t arbitrate(input logic a, input logic b, input logic pb);
        return (a && (!b || !pb)) ? OWN_A : b ? OWN_B : IDLE;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_q, last_d;
    assign last_d   = (state_d == OWN_A) ? OWNER_A : (state_d == OWN_B) ? OWNER_B : last_q;
    assign prefer_b = (last_q == OWNER_A);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= OWNER_B;
        else        last_q <= last_d;
    end
`else
    assign prefer_b = 1'b0;
`endif

    assign own     = (state_q != IDLE);
    assign own_req = (state_q == OWN_A) ? reqA : reqB;
    assign cnt_en  = own && own_req && !busAck;

    bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!cnt_en),
        .enable  (cnt_en),
        .expired (expired)
    );

    // An ack completes the transfer even if the owner withdraws in the same cycle.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (!own || busAck) begin
            state_d = arbitrate(reqA, reqB, prefer_b);
        end else if (!own_req || expired) begin
            state_d = IDLE;
            err_d   = expired;
        end
        useA_d = (state_d == OWN_A) ? 1'b1 : (state_d == OWN_B) ? 1'b0 : useA_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            useA_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            useA_q  <= useA_d;
            err_q   <= err_d;
        end
    end

    assign grantA     = (state_q == OWN_A);
    assign grantB     = (state_q == OWN_B);
    assign useA       = useA_q;
    assign timeoutErr = err_q;
    assign busValid   = (grantA & reqA) | (grantB & reqB);
endmodule

// File: doc/master_bus_arbiter.md
Name: master_bus_arbiter

Overview:
- Upstream control stage for the two-master bus multiplexer. Decides which master owns the shared memory bus: master A (instruction fetch) or master B (data load/store).
- Drives the mux select `useA` and per-master grants.
- Tracks transaction completion through the slave acknowledge.
- Recovers from hung transactions with a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: number of cycles without `busAck` in an OWN state before forced release. 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter (derived, not overridden).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- reqA  input  1  master A requests the bus; held high until acknowledged
- reqB  input  1  master B requests the bus; held high until acknowledged
- busAck  input  1  slave completes the current transfer this cycle
- useA  output  1  mux select: 1 routes A to the common bus, 0 routes B
- grantA  output  1  A owns the bus this cycle
- grantB  output  1  B owns the bus this cycle
- busValid  output  1  common bus carries a live request
- timeoutErr  output  1  one-cycle pulse on forced release

Behaviour:
- Reset values (async assert, sync deassert by the reset tree):
  - state=IDLE, useA=1, grantA=0, grantB=0, busValid=0, timeoutErr=0
  - counter=0, lastOwner=B
- States: IDLE, OWN_A, OWN_B. All outputs are registered except busValid, which is defined as (grantA&reqA)|(grantB&reqB).
- IDLE:
  - reqA only -> OWN_A; reqB only -> OWN_B.
  - Both -> fixed priority A (see Optional Feature).
  - Neither -> stay.
  - Grant is visible the cycle after the request: 1-cycle arbitration latency.
  - useA holds its last value in IDLE, so the mux never toggles without an owner.
- OWN_x with busAck=1 (transfer done): re-arbitrate in the same cycle with the IDLE rules; the other master wins if it is requesting (subject to priority).
  - Back-to-back transfers: no IDLE bubble when another request is pending.
  - Owner re-requesting alone keeps the grant.
- OWN_x with req_x=0 before ack (master withdrawal): return to IDLE next cycle, no error, counter cleared.
- busAck is ignored in IDLE.
- Timeout counter:
  - Cleared on every state entry and on every ack.
  - Increments each cycle in OWN_x without ack.
  - When counter == TIMEOUT_CYCLES-1 and no ack: next state is IDLE, timeoutErr pulses for exactly 1 cycle, grant drops.
  - Ack in the same cycle as expiry wins: no error.
- Simultaneous ack and withdrawal: treated as completion.
- Reset asserted mid-transfer: all outputs go to reset values immediately; the in-flight transfer is abandoned.
- grantA and grantB are never both 1. useA==1 whenever grantA==1, and useA==0 whenever grantB==1.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined: when both masters request in an arbitration cycle, grant goes to the master that is not lastOwner. lastOwner updates on every grant.
- Undefined: fixed priority to A; lastOwner register is not built. B may starve while A requests continuously.

Decomposition:
- Common package: arb_state_t enum (IDLE, OWN_A, OWN_B) and owner_t enum (OWNER_A, OWNER_B).
- One sub-module, bus_timeout_counter: inputs clear, enable; output expired.
- The arbitration decision stays as a combinational function inside master_bus_arbiter.

Test Plan:
1. Reset, then reqA=1 at cycle 0 and busAck=1 at cycle 3:
   - grantA=1 and useA=1 at cycles 1-3, busValid=1 at cycles 1-3.
   - IDLE at cycle 4 if reqA drops.
2. reqA=reqB=1 held, busAck every 2 cycles:
   - Fixed build: grantA continuously, grantB=0.
   - ARB_ROUND_ROBIN_EN build: grants alternate A,B,A,B with no idle cycle between.
3. TIMEOUT_CYCLES=4, reqB=1 held, no ack:
   - grantB for 4 cycles, then timeoutErr=1 for one cycle.
   - Grant drops, then re-grant to B the following cycle.
4. Ack on the same cycle the counter expires -> no timeoutErr, normal handoff.
5. reqA withdrawn at cycle 2 of ownership -> IDLE next cycle, no error; subsequent reqB granted one cycle later with useA=0.
6. rst_n pulsed low mid-OWN_B -> grantB=0, busValid=0, useA=1 immediately, without waiting for a clock edge.
